scaler_linear_mc: RTL and testbench
===================================

# scaler_linear_mc

Multi-channel horizontal video scaler with a run-time programmable step and two interpolation modes: linear (2-tap) and nearest-neighbour. It generalises the single-channel scaler with a fixed step to CHANNELS packed components (e.g. B,G,R) and to frame-synchronous step/mode updates. It sits in the video pipeline between a source with gapped de_i and a downstream consumer. It uses ping-pong line buffers, so the output runs one line behind the input.

## Interface
- LINE_SIZE_MAX, 4096: maximum input pixels per line; sets buffer depth and counter width.
- CHANNELS, 3: components per pixel, packed LSB-first (ch0 = bits [DATA_WIDTH-1:0]).
- DATA_WIDTH, 8: bits per component.
- STEP_WIDTH, 16: step width, unsigned 4.12 fixed point; 4096 = 1.0.

- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- step_i  in  STEP_WIDTH  input-coordinate increment per output pixel; <4096 upscales, >4096 downscales; 0 is illegal.
- mode_i  in  1  0 = linear, 1 = nearest.
- di_i  in  CHANNELS*DATA_WIDTH  input pixel.
- de_i  in  1  input pixel valid; gaps allowed.
- hs_i  in  1  high = horizontal blanking.
- vs_i  in  1  high = vertical blanking.
- do_o  out  CHANNELS*DATA_WIDTH  scaled pixel.
- de_o  out  1  output pixel valid.
- hs_o  out  1  high = output horizontal blanking.
- vs_o  out  1  high = output vertical blanking.
- ovf_o  out  1  one-cycle pulse: a readout was aborted.

## Operation
- Write side: each de_i writes di_i to the write bank at wr_cnt, then wr_cnt increments. Write counts beyond LINE_SIZE_MAX are discarded.
- Line end: hs_i is sampled 1 after having been 0, with wr_cnt ≥ 1. The block then latches W = wr_cnt, swaps banks, clears wr_cnt and requests a readout. A line with wr_cnt = 0 is ignored.
- Shadow registers: step_i and mode_i are captured into the shadow registers on the falling edge of vs_i (frame start). At each readout start, the working registers are loaded from the shadow registers. A readout in progress never changes its step.
- FSM states:
  - IDLE → RUN on a readout request.
  - RUN issues one coordinate per clock, cord = k*step with k = 0,1,….
  - RUN → IDLE after issuing the last coordinate with cord < W<<12.
- Output count: N_out = ceil(W*4096/step).
- Coordinate and sample selection: idx = cord>>12, f = cord[11:0]. The coordinate register is 12+clog2(LINE_SIZE_MAX)+1 bits. p[idx+1] clamps to p[W-1].
- Reads: both taps are read in the same cycle (two read ports per bank).
- Linear mode, per channel: out = (p[idx]*(4096-f) + p[idx+1]*f + 2048) >> 12. The result fits DATA_WIDTH with no saturation needed.
- Nearest mode, per channel: out = p[idx + (f ≥ 2048)], with the index clamped.
- Collision: if a new line end arrives while in RUN, the current readout is aborted, ovf_o pulses, and the new readout starts on the next cycle. Pixels already in the pipeline still emerge.
- vs_o:
  - Rises when vs_i = 1, the FSM is in IDLE, no request is pending, and the pipeline is empty.
  - Falls one cycle after vs_i falls.
- Reset mid-line: all state clears, and any partial line or readout is dropped.

## Timing
- Reset values: do_o = 0, de_o = 0, hs_o = 1, vs_o = 1, ovf_o = 0. Both banks are logically empty and the FSM is in IDLE.
- Readout pipeline: address issue → RAM read → multiply → round/register. de_o is asserted exactly 4 clocks after the clock edge on which the line-end hs_i = 1 was sampled.
- de_o is continuous, with one pixel per clock for N_out clocks and no gaps.
- hs_o is 0 exactly while de_o = 1 within a line, and 1 otherwise. It falls on the same cycle as the first de_o and rises the cycle after the last.
- The input line period must exceed N_out+4 clocks; otherwise the collision rule applies.
- The block has no back-pressure.

## Test plan
- Identity: W = 4, ch0 = [10,20,30,40], step = 4096, linear → de_o 4 cycles wide, do_o ch0 = 10,20,30,40, first de_o 4 clocks after hs_i rises.
- Upscale ×2, linear: [0,100,200,100], step = 2048 → 8 outputs 0,50,100,150,200,150,100,100.
- Same input, nearest → 0,100,100,200,200,100,100,100.
- Downscale: step = 8192 → 2 outputs 0,200. step = 5283 (≈1.29) on W = 25 → N_out = 20.
- Step change: step_i changed mid-frame is ignored until the vs_i falling edge. Lines of the next frame use the new value, verified by N_out per line.
- Collision: W = 8, step = 1024 (N_out = 32), with the next line ending 20 clocks later → ovf_o pulses once, the first readout stops, and the second line outputs a full 32 pixels. Also: channel independence with ch1/ch2 different ramps, and reset asserted mid-readout returns de_o = 0 and hs_o = 1 on the next cycle.

Source files
------------

// File: rtl/scaler_linear_mc.sv
// Multi-channel horizontal video scaler: ping-pong line buffers, run-time 4.12 step,
// linear or nearest-neighbour interpolation; output runs one line behind input.
module scaler_linear_mc #(
  parameter int unsigned LINE_SIZE_MAX = 4096,
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned STEP_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STEP_WIDTH-1:0]          step_i,
  input  logic                           mode_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] di_i,
  input  logic                           de_i,
  input  logic                           hs_i,
  input  logic                           vs_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] do_o,
  output logic                           de_o,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic                           ovf_o
);

  localparam int unsigned AW   = $clog2(LINE_SIZE_MAX);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = 12 + AW + 1;
  localparam int unsigned PW   = CHANNELS * DATA_WIDTH;
  localparam int unsigned SW   = DATA_WIDTH + 12;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cord_q, cord_d;
  logic [STEP_WIDTH-1:0] run_step_q, run_step_d;
  logic                  run_mode_q, run_mode_d;
  logic [STEP_WIDTH-1:0] shadow_step_q;
  logic                  shadow_mode_q;
  logic                  hs_prev_q, vs_prev_q;
  logic [CNTW-1:0]       wr_cnt_q, line_w_q;
  logic                  wr_bank_q, req_q;
  logic                  v1_q, v2_q;
  logic [PW-1:0]         do_q;
  logic                  de_q, hs_q, vs_q, ovf_q;

  logic [PW-1:0]         mem [2][LINE_SIZE_MAX];
  logic [PW-1:0]         tap0_q, tap1_q;
  logic [11:0]           f1_q;
  logic [SW-1:0]         sum_q [CHANNELS];

  logic                  line_end, wr_en, issue, req_d, vs_d;
  logic [CNTW-1:0]       idx, idx_nx, idx_hi, w_last;
  logic [11:0]           f, f_eff;
  logic [AW-1:0]         addr0, addr1;
  logic [CW-1:0]         cord_next, limit;
  logic [SW-1:0]         prod [CHANNELS];
  logic [PW-1:0]         do_d;

  // A line ends on the rising edge of hs_i, but only if it carried pixels.
  assign line_end = hs_i & ~hs_prev_q & (wr_cnt_q != '0);
  assign wr_en    = de_i & (wr_cnt_q < CNTW'(LINE_SIZE_MAX));
  assign issue    = (state_q == StRun);

  assign cord_next = cord_q + CW'(run_step_q);
  assign limit     = {line_w_q, 12'd0};

  always_comb begin
    state_d    = state_q;
    cord_d     = cord_q;
    run_step_d = run_step_q;
    run_mode_d = run_mode_q;
    req_d      = req_q;
    unique case (state_q)
      StIdle: begin
        if (req_q) begin
          state_d    = StRun;
          cord_d     = '0;
          run_step_d = shadow_step_q;
          run_mode_d = shadow_mode_q;
          req_d      = 1'b0;
        end
      end
      StRun: begin
        if (line_end || (cord_next >= limit)) begin
          state_d = StIdle;
        end else begin
          cord_d = cord_next;
        end
      end
      default: state_d = StIdle;
    endcase
    if (line_end) begin
      req_d = 1'b1;
    end
  end

  // Tap selection; nearest mode reuses the linear datapath with a zero fraction.
  always_comb begin
    idx    = cord_q[CW-1:12];
    f      = cord_q[11:0];
    idx_nx = idx + CNTW'(1);
    w_last = line_w_q - CNTW'(1);
    idx_hi = (idx_nx > w_last) ? w_last : idx_nx;
    addr0  = AW'((run_mode_q && f[11]) ? idx_hi : idx);
    addr1  = AW'(idx_hi);
    f_eff  = run_mode_q ? 12'd0 : f;
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      prod[c] = SW'(tap0_q[c*DATA_WIDTH +: DATA_WIDTH]) * SW'(13'd4096 - {1'b0, f1_q})
              + SW'(tap1_q[c*DATA_WIDTH +: DATA_WIDTH]) * SW'(f1_q);
    end
  end

  always_comb begin
    do_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      do_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((sum_q[c] + SW'(2048)) >> 12);
    end
  end

  // vs_o only rises once the previous line has fully drained.
  always_comb begin
    vs_d = vs_q;
    if (vs_i && (state_q == StIdle) && !req_q && !v1_q && !v2_q && !de_q) begin
      vs_d = 1'b1;
    end else if (!vs_i) begin
      vs_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank_q][wr_cnt_q[AW-1:0]] <= di_i;
    end
    tap0_q <= mem[~wr_bank_q][addr0];
    tap1_q <= mem[~wr_bank_q][addr1];
    f1_q   <= f_eff;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_q[c] <= prod[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cord_q        <= '0;
      run_step_q    <= STEP_WIDTH'(4096);
      run_mode_q    <= 1'b0;
      shadow_step_q <= STEP_WIDTH'(4096);
      shadow_mode_q <= 1'b0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b0;
      wr_cnt_q      <= '0;
      line_w_q      <= '0;
      wr_bank_q     <= 1'b0;
      req_q         <= 1'b0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      do_q          <= '0;
      de_q          <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      ovf_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      cord_q     <= cord_d;
      run_step_q <= run_step_d;
      run_mode_q <= run_mode_d;
      req_q      <= req_d;
      hs_prev_q  <= hs_i;
      vs_prev_q  <= vs_i;
      if (vs_prev_q && !vs_i) begin
        shadow_step_q <= step_i;
        shadow_mode_q <= mode_i;
      end
      if (line_end) begin
        line_w_q  <= wr_cnt_q;
        wr_bank_q <= ~wr_bank_q;
        wr_cnt_q  <= '0;
      end else if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + CNTW'(1);
      end
      v1_q  <= issue;
      v2_q  <= v1_q;
      de_q  <= v2_q;
      hs_q  <= ~v2_q;
      do_q  <= do_d;
      vs_q  <= vs_d;
      ovf_q <= line_end & issue;
    end
  end

  assign do_o  = do_q;
  assign de_o  = de_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_scaler_linear_mc.sv
// Directed bench for scaler_linear_mc: scaling ratios, modes, shadowed step, collision, reset.
module tb_scaler_linear_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] step_i;
  logic        mode_i;
  logic [23:0] di_i;
  logic        de_i, hs_i, vs_i;
  logic [23:0] do_o;
  logic        de_o, hs_o, vs_o, ovf_o;

  scaler_linear_mc #(
    .LINE_SIZE_MAX(4096),
    .CHANNELS     (3),
    .DATA_WIDTH   (8),
    .STEP_WIDTH   (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .step_i(step_i),
    .mode_i(mode_i),
    .di_i  (di_i),
    .de_i  (de_i),
    .hs_i  (hs_i),
    .vs_i  (vs_i),
    .do_o  (do_o),
    .de_o  (de_o),
    .hs_o  (hs_o),
    .vs_o  (vs_o),
    .ovf_o (ovf_o)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          n_ovf = 0, hs_bad = 0;
  bit          mon_en = 1'b0;
  logic [23:0] q[$];
  int          t_q[$];
  logic [23:0] pix[$];
  logic [23:0] exp_q[$];
  int          base, e0, e0a, e0b, ovf0, na, nb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (de_o) begin
        q.push_back(do_o);
        t_q.push_back(cyc);
      end
      if (ovf_o) n_ovf++;
      if (hs_o !== ~de_o) hs_bad++;
    end
  end

  function automatic logic [23:0] px(input int c2, input int c1, input int c0);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_frame(input int step, input bit mode);
    vs_i = 1'b1;
    tick;
    tick;
    chk("vs_o_high_in_blank", 32'(vs_o), 1);
    step_i = 16'(step);
    mode_i = mode;
    vs_i   = 1'b0;
    tick;
    chk("vs_o_falls", 32'(vs_o), 0);
  endtask

  task automatic send_line(input bit mark);
    if (mark) base = q.size();
    hs_i = 1'b0;
    for (int i = 0; i < pix.size(); i++) begin
      de_i = 1'b1;
      di_i = pix[i];
      tick;
    end
    de_i = 1'b0;
    di_i = '0;
    hs_i = 1'b1;
    tick;
    e0 = cyc;
  endtask

  task automatic check_line(input string tag, input int n_exp);
    int n;
    n = q.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(n_exp));
    if (n > 0) begin
      chk({tag, "_latency"}, 32'(t_q[base] - e0), 4);
      chk({tag, "_contiguous"}, 32'(t_q[q.size()-1] - t_q[base]), 32'(n - 1));
    end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk($sformatf("%s_px%0d", tag, i), 32'(q[base+i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    rst = 1'b1; vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0; di_i = '0;
    step_i = 16'd4096; mode_i = 1'b0;
    repeat (3) tick;
    chk("rst_do", 32'(do_o), 0);
    chk("rst_de", 32'(de_o), 0);
    chk("rst_hs", 32'(hs_o), 1);
    chk("rst_vs", 32'(vs_o), 1);
    chk("rst_ovf", 32'(ovf_o), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick;

    // Identity
    set_frame(4096, 1'b0);
    pix = '{px(200, 1, 10), px(150, 2, 20), px(100, 3, 30), px(50, 4, 40)};
    send_line(1'b1);
    repeat (12) tick;
    exp_q = pix;
    check_line("ident", 4);

    // Upscale x2, linear, three independent channels
    set_frame(2048, 1'b0);
    pix = '{px(255, 10, 0), px(0, 20, 100), px(128, 30, 200), px(7, 40, 100)};
    send_line(1'b1);
    repeat (16) tick;
    exp_q = '{px(255, 10, 0), px(128, 15, 50), px(0, 20, 100), px(64, 25, 150),
              px(128, 30, 200), px(68, 35, 150), px(7, 40, 100), px(7, 40, 100)};
    check_line("up_lin", 8);

    // Upscale x2, nearest
    set_frame(2048, 1'b1);
    send_line(1'b1);
    repeat (16) tick;
    exp_q = '{px(255, 10, 0), px(0, 20, 100), px(0, 20, 100), px(128, 30, 200),
              px(128, 30, 200), px(7, 40, 100), px(7, 40, 100), px(7, 40, 100)};
    check_line("up_near", 8);

    // Downscale x2
    set_frame(8192, 1'b0);
    send_line(1'b1);
    repeat (10) tick;
    exp_q = '{px(255, 10, 0), px(128, 30, 200)};
    check_line("down2", 2);

    // Non-integer downscale, W=25
    set_frame(5283, 1'b0);
    pix.delete();
    for (int i = 0; i < 25; i++) pix.push_back(px(0, 0, i * 10));
    send_line(1'b1);
    repeat (30) tick;
    exp_q.delete();
    check_line("down_frac", 20);
    if (q.size() - base == 20) begin
      chk("down_frac_px1", 32'(q[base+1]), 32'(px(0, 0, 13)));
      chk("down_frac_last", 32'(q[base+19]), 32'(px(0, 0, 240)));
    end

    // Step change mid-frame stays shadowed until the next frame start
    set_frame(4096, 1'b0);
    step_i = 16'd2048;
    pix = '{px(0, 0, 10), px(0, 0, 20), px(0, 0, 30), px(0, 0, 40)};
    send_line(1'b1);
    repeat (12) tick;
    exp_q = pix;
    check_line("shadow_old", 4);
    set_frame(2048, 1'b0);
    send_line(1'b1);
    repeat (16) tick;
    exp_q.delete();
    check_line("shadow_new", 8);

    // Collision: second line end 20 clocks after the first
    chk("no_ovf_before_collision", 32'(n_ovf), 0);
    ovf0 = n_ovf;
    set_frame(1024, 1'b0);
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(px(0, 0, 5));
    send_line(1'b1);
    e0a = e0;
    repeat (11) tick;
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(px(0, 0, i * 8));
    send_line(1'b0);
    e0b = e0;
    chk("collision_spacing", 32'(e0b - e0a), 20);
    repeat (45) tick;
    chk("collision_ovf_pulses", 32'(n_ovf - ovf0), 1);
    na = 0;
    nb = 0;
    for (int i = base; i < q.size(); i++) begin
      if (t_q[i] <= e0b + 3) begin
        na++;
      end else begin
        if (nb == 0) chk("coll_b_latency", 32'(t_q[i] - e0b), 4);
        chk($sformatf("coll_b_px%0d", nb), 32'(q[i]),
            32'(px(0, 0, (nb < 28) ? 2 * nb : 56)));
        nb++;
      end
    end
    chk("coll_a_count", 32'(na), 19);
    chk("coll_b_count", 32'(nb), 32);
    if (na > 0) chk("coll_a_px0", 32'(q[base]), 32'(px(0, 0, 5)));

    // Reset mid-readout
    set_frame(1024, 1'b0);
    send_line(1'b1);
    repeat (6) tick;
    chk("pre_reset_de", 32'(de_o), 1);
    rst = 1'b1;
    tick;
    chk("mid_reset_de", 32'(de_o), 0);
    chk("mid_reset_hs", 32'(hs_o), 1);
    rst = 1'b0;
    repeat (4) tick;
    chk("post_reset_de", 32'(de_o), 0);
    chk("hs_tracks_de", 32'(hs_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
